// File: rtl/grant_ctrl.sv
// Four-way round-robin grant controller with bounded tenure and a forced dead cycle
// between grants. Grants, busy, owner and expired are all registered.
module grant_ctrl #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       r0,
   input  logic       r1,
   input  logic       r2,
   input  logic       r3,
   output logic       g0,
   output logic       g1,
   output logic       g2,
   output logic       g3,
   output logic       busy,
   output logic [1:0] owner,
   output logic       expired,
   output logic       R
);

   typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_e;

   localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

   state_e     r_state;
   logic [3:0] r_grant;
   logic       r_busy;
   logic [1:0] r_owner;
   logic       r_expired;
   logic [1:0] r_last;
   logic [7:0] r_hold_cnt;

   logic [3:0] w_req;
   logic       w_any;
   logic [1:0] w_win;
   logic [1:0] w_idx;
   logic       w_owner_req;
   logic       w_hold_done;

   assign w_req       = {r3, r2, r1, r0};
   assign w_any       = |w_req;
   assign w_owner_req = w_req[r_last];
   assign w_hold_done = (r_hold_cnt == HoldLast);

   // Scan from farthest to nearest so the first requester after r_last wins.
   always_comb begin
      w_win = r_last;
      w_idx = r_last;
      for (int k = 4; k >= 1; k--) begin
         w_idx = r_last + 2'(k);
         if (w_req[w_idx]) begin
            w_win = w_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= StIdle;
         r_grant    <= 4'b0000;
         r_busy     <= 1'b0;
         r_owner    <= 2'd0;
         r_expired  <= 1'b0;
         r_last     <= 2'd3;
         r_hold_cnt <= 8'd0;
      end else begin
         unique case (r_state)
            StIdle, StTurn: begin
               r_expired <= 1'b0;
               if (w_any) begin
                  r_state    <= StGrant;
                  r_grant    <= 4'b0001 << w_win;
                  r_busy     <= 1'b1;
                  r_owner    <= w_win;
                  r_last     <= w_win;
                  r_hold_cnt <= 8'd0;
               end else begin
                  r_state <= StIdle;
               end
            end
            StGrant: begin
               r_hold_cnt <= r_hold_cnt + 8'd1;
               if (!w_owner_req || w_hold_done) begin
                  r_state   <= StTurn;
                  r_grant   <= 4'b0000;
                  r_busy    <= 1'b0;
                  r_owner   <= 2'd0;
                  // A simultaneous release wins over the timeout.
                  r_expired <= w_owner_req;
               end
            end
            default: begin
               r_state   <= StIdle;
               r_grant   <= 4'b0000;
               r_busy    <= 1'b0;
               r_owner   <= 2'd0;
               r_expired <= 1'b0;
            end
         endcase
      end
   end

   assign g0      = r_grant[0];
   assign g1      = r_grant[1];
   assign g2      = r_grant[2];
   assign g3      = r_grant[3];
   assign busy    = r_busy;
   assign owner   = r_owner;
   assign expired = r_expired;
   assign R       = w_any;

endmodule

// File: tb/tb_grant_ctrl.sv
// Self-checking bench for grant_ctrl: directed scenarios plus a randomized run against a
// tenure-level reference model.
module tb_grant_ctrl;

   localparam int unsigned MAX_HOLD = 16;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic       g0, g1, g2, g3;
   logic       busy;
   logic [1:0] owner;
   logic       expired;
   logic       R;
   logic [3:0] g;
   logic [7:0] obs;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: current owner (-1 none), granted cycles so far, last winner.
   int m_own  = -1;
   int m_len  = 0;
   int m_last = 3;
   bit m_exp  = 1'b0;

   grant_ctrl #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .r0      (req[0]),
      .r1      (req[1]),
      .r2      (req[2]),
      .r3      (req[3]),
      .g0      (g0),
      .g1      (g1),
      .g2      (g2),
      .g3      (g3),
      .busy    (busy),
      .owner   (owner),
      .expired (expired),
      .R       (R)
   );

   assign g   = {g3, g2, g1, g0};
   assign obs = {g, busy, owner, expired};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic model_reset();
      m_own  = -1;
      m_len  = 0;
      m_last = 3;
      m_exp  = 1'b0;
   endtask

   task automatic model_step();
      if (m_own >= 0) begin
         m_exp = 1'b0;
         if (!req[m_own]) begin
            m_own = -1;
         end else if (m_len == int'(MAX_HOLD)) begin
            m_own = -1;
            m_exp = 1'b1;
         end else begin
            m_len++;
         end
      end else begin
         m_exp = 1'b0;
         for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_last + k) % 4;
            if (req[c]) begin
               m_own  = c;
               m_last = c;
               m_len  = 1;
               break;
            end
         end
      end
   endtask

   function automatic logic [7:0] exp_vec();
      logic [7:0] v;
      v = 8'h00;
      if (m_own >= 0) begin
         v[7:4] = 4'b0001 << m_own;
         v[3]   = 1'b1;
         v[2:1] = 2'(m_own);
      end
      v[0] = m_exp;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      req   = 4'b0000;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      req   = 4'b0000;
      #1 rst_n = 1'b0;
      req = 4'b0101;
      #1;
      n_checks++;
      if (obs !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h, want %h", obs, 8'h00);
      end
      n_checks++;
      if (R !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_R_high: got %b, want 1", R);
      end
      req = 4'b0000;
      #1;
      n_checks++;
      if (R !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_R_low: got %b, want 0", R);
      end
      req = 4'b1111;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (obs !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_held: got %h, want %h", obs, 8'h00);
      end
      req = 4'b0000;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_rotation();
      do_reset();
      req = 4'b1111;
      for (int c = 1; c <= 4; c++) begin
         tick();
         n_checks++;
         if (obs !== 8'h18) begin
            n_fail++;
            $display("FAIL rotation_g0_c%0d: got %h, want %h", c, obs, 8'h18);
         end
      end
      req = 4'b1110;
      tick();
      n_checks++;
      if (obs !== 8'h00) begin
         n_fail++;
         $display("FAIL rotation_turn: got %h, want %h", obs, 8'h00);
      end
      tick();
      n_checks++;
      if (obs !== 8'h2a) begin
         n_fail++;
         $display("FAIL rotation_g1: got %h, want %h", obs, 8'h2a);
      end
   endtask

   task automatic test_timeout();
      int n_exp;
      logic [7:0] want;
      n_exp = 0;
      do_reset();
      req = 4'b0100;
      for (int c = 1; c <= 40; c++) begin
         tick();
         want = (((c - 1) % (MAX_HOLD + 1)) == MAX_HOLD) ? 8'h01 : 8'h4c;
         if (expired === 1'b1) n_exp++;
         n_checks++;
         if (obs !== want) begin
            n_fail++;
            $display("FAIL timeout_c%0d: got %h, want %h", c, obs, want);
         end
      end
      n_checks++;
      if (n_exp != 2) begin
         n_fail++;
         $display("FAIL timeout_pulses: got %0d, want 2", n_exp);
      end
   endtask

   task automatic test_no_preempt();
      do_reset();
      req = 4'b0010;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (c == 3) req = 4'b1010;
         n_checks++;
         if (obs !== 8'h2a) begin
            n_fail++;
            $display("FAIL no_preempt_c%0d: got %h, want %h", c, obs, 8'h2a);
         end
      end
      req = 4'b1000;
      tick();
      n_checks++;
      if (obs !== 8'h00) begin
         n_fail++;
         $display("FAIL no_preempt_turn: got %h, want %h", obs, 8'h00);
      end
      tick();
      n_checks++;
      if (obs !== 8'h8e) begin
         n_fail++;
         $display("FAIL no_preempt_g3: got %h, want %h", obs, 8'h8e);
      end
   endtask

   task automatic test_release_at_limit();
      do_reset();
      req = 4'b0001;
      for (int c = 1; c <= int'(MAX_HOLD); c++) begin
         tick();
         n_checks++;
         if (obs !== 8'h18) begin
            n_fail++;
            $display("FAIL limit_hold_c%0d: got %h, want %h", c, obs, 8'h18);
         end
      end
      req = 4'b0000;
      tick();
      n_checks++;
      if (obs !== 8'h00) begin
         n_fail++;
         $display("FAIL limit_release: got %h, want %h", obs, 8'h00);
      end
      tick();
      n_checks++;
      if (obs !== 8'h00) begin
         n_fail++;
         $display("FAIL limit_idle: got %h, want %h", obs, 8'h00);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      req = 4'b0010;
      tick();
      tick();
      n_checks++;
      if (obs !== 8'h2a) begin
         n_fail++;
         $display("FAIL async_pre: got %h, want %h", obs, 8'h2a);
      end
      req = 4'b1001;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (obs !== 8'h00) begin
         n_fail++;
         $display("FAIL async_clear: got %h, want %h", obs, 8'h00);
      end
      n_checks++;
      if (R !== 1'b1) begin
         n_fail++;
         $display("FAIL async_R: got %b, want 1", R);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (obs !== 8'h18) begin
         n_fail++;
         $display("FAIL async_first_g0: got %h, want %h", obs, 8'h18);
      end
   endtask

   task automatic test_random();
      logic [3:0] prev_g;
      int         run;
      int         waits[4];
      logic [7:0] want;
      prev_g = 4'b0000;
      run    = 0;
      for (int i = 0; i < 4; i++) waits[i] = 0;
      do_reset();
      for (int cyc = 0; cyc < 10000; cyc++) begin
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 19) == 0) req[i] = ~req[i];
         end
         tick();
         want = exp_vec();
         n_checks++;
         if (obs !== want) begin
            n_fail++;
            $display("FAIL random_model cyc %0d: got %h, want %h", cyc, obs, want);
         end
         n_checks++;
         if (!$onehot0(g)) begin
            n_fail++;
            $display("FAIL random_onehot cyc %0d: got %b, want at most one bit", cyc, g);
         end
         n_checks++;
         if (busy !== (|g)) begin
            n_fail++;
            $display("FAIL random_busy cyc %0d: got %b, want %b", cyc, busy, |g);
         end
         if (g != 4'b0000 && g == prev_g) run++;
         else if (g != 4'b0000) run = 1;
         else run = 0;
         n_checks++;
         if (run > int'(MAX_HOLD)) begin
            n_fail++;
            $display("FAIL random_tenure cyc %0d: got %0d cycles, want <= %0d", cyc, run,
                     MAX_HOLD);
         end
         for (int i = 0; i < 4; i++) begin
            if (g[i] || !req[i]) waits[i] = 0;
            else if (g != 4'b0000 && g != prev_g) waits[i]++;
         end
         n_checks++;
         if (waits[0] > 3 || waits[1] > 3 || waits[2] > 3 || waits[3] > 3) begin
            n_fail++;
            $display("FAIL random_starve cyc %0d: got waits %0d/%0d/%0d/%0d, want <= 3", cyc,
                     waits[0], waits[1], waits[2], waits[3]);
         end
         prev_g = g;
      end
   endtask

   initial begin
      req   = 4'b0000;
      rst_n = 1'b1;
      test_reset();
      test_rotation();
      test_timeout();
      test_no_preempt();
      test_release_at_limit();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
